// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE between grants, BURST while a requester owns the port)
//   ARB_MAX_REQ : largest supported number of requesters
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int ARB_MAX_REQ = 8;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the producer handshake and FIFO write-port signals.
//   req_valid/req_data/req_ready : per-requester valid/ready, data packed at [i*DATA_W +: DATA_W]
//   full/wr_en/D_in              : FIFO write pins
//   gnt_valid/gnt_id             : current port ownership
// master = arbiter side, slave = producers + FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      full;
  logic                      wr_en;
  logic [DATA_W-1:0]         D_in;
  logic                      gnt_valid;
  logic [IDX_W-1:0]          gnt_id;

  modport master (
    input  req_valid, req_data, full,
    output req_ready, wr_en, D_in, gnt_valid, gnt_id
  );

  modport slave (
    output req_valid, req_data, full,
    input  req_ready, wr_en, D_in, gnt_valid, gnt_id
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req      : request vector
//   last_gnt : index that held the grant last (lowest priority this round)
//   found    : at least one request present
//   idx      : first requesting index after last_gnt, wrapping modulo NUM_REQ
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);
  import fifo_arb_pkg::*;

  int cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    // Scan starting one past last_gnt so the previous owner is examined last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_gnt) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   flush : synchronous soft clear (drop grant, reset round-robin pointer)
//   bus   : handshake/FIFO interface (master modport)
// A grant is taken in IDLE and held for up to MAX_BURST beats; the owner loses it
// early when it drops req_valid. FIFO full stalls the burst without losing the grant.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  fifo_wr_arbiter_if.master  bus
);
  import fifo_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_t       state_q, state_n;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_n;
  logic [IDX_W-1:0] last_gnt_q, last_gnt_n;
  logic             gnt_valid_q, gnt_valid_n;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_n;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_valid;
  logic             beat;
  logic             last_beat;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (bus.req_valid),
    .last_gnt (last_gnt_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign owner_valid = bus.req_valid[gnt_id_q];
  // flush suppresses the write in its own cycle.
  assign beat      = (state_q == BURST) && owner_valid && !bus.full && !flush;
  assign last_beat = (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_id_q    <= '0;
      last_gnt_q  <= IDX_W'(NUM_REQ - 1);
      gnt_valid_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_n;
      gnt_id_q    <= gnt_id_n;
      last_gnt_q  <= last_gnt_n;
      gnt_valid_q <= gnt_valid_n;
      beat_cnt_q  <= beat_cnt_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    gnt_id_n    = gnt_id_q;
    last_gnt_n  = last_gnt_q;
    gnt_valid_n = gnt_valid_q;
    beat_cnt_n  = beat_cnt_q;
    if (flush) begin
      state_n     = IDLE;
      last_gnt_n  = IDX_W'(NUM_REQ - 1);
      gnt_valid_n = 1'b0;
      beat_cnt_n  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_n     = BURST;
            gnt_id_n    = pick_idx;
            gnt_valid_n = 1'b1;
            beat_cnt_n  = '0;
          end
        end
        BURST: begin
          if (!owner_valid || (beat && last_beat)) begin
            state_n     = IDLE;
            last_gnt_n  = gnt_id_q;
            gnt_valid_n = 1'b0;
          end else if (beat) begin
            beat_cnt_n = beat_cnt_q + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Write port is a pure function of the registered grant and live inputs so the
  // handshake and the FIFO write happen in the same cycle.
  always_comb begin
    bus.wr_en     = beat;
    bus.D_in      = '0;
    bus.req_ready = '0;
    if (beat) begin
      bus.D_in                = bus.req_data[gnt_id_q*DATA_W +: DATA_W];
      bus.req_ready[gnt_id_q] = 1'b1;
    end
  end

  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst;
  logic flush;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus();

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port, how many bytes it has written this grant,
  // and who owned it last.
  int m_owner = -1;
  int m_beats = 0;
  int m_last  = NUM_REQ - 1;

  // Observations of the DUT, used by the directed literal checks.
  logic [7:0] wr_q[$];
  int         grant_q[$];
  int         wr_cnt     = 0;
  int         burst_len  = 0;
  int         last_burst = -1;
  logic       prev_gv    = 1'b0;

  always @(negedge clk) begin
    logic             exp_wr;
    logic [7:0]       exp_data;
    logic [NUM_REQ-1:0] exp_ready;
    logic             exp_gv;
    if (rst) begin
      m_owner = -1;
      m_beats = 0;
      m_last  = NUM_REQ - 1;
    end
    exp_wr    = 1'b0;
    exp_data  = 8'h00;
    exp_ready = '0;
    exp_gv    = (m_owner >= 0);
    if (!rst && m_owner >= 0 && !flush && bus.req_valid[m_owner] && !bus.full) begin
      exp_wr             = 1'b1;
      exp_data           = bus.req_data[m_owner*DATA_W +: DATA_W];
      exp_ready[m_owner] = 1'b1;
    end
    chk("wr_en", bus.wr_en, exp_wr);
    chk("D_in", bus.D_in, exp_data);
    chk("req_ready", bus.req_ready, exp_ready);
    chk("gnt_valid", bus.gnt_valid, exp_gv);
    if (exp_gv) chk("gnt_id", bus.gnt_id, m_owner);

    if (bus.gnt_valid && !prev_gv) begin
      grant_q.push_back(int'(bus.gnt_id));
      burst_len = 0;
    end
    if (bus.wr_en) begin
      wr_q.push_back(bus.D_in);
      wr_cnt++;
      burst_len++;
    end
    if (!bus.gnt_valid && prev_gv) last_burst = burst_len;
    prev_gv = bus.gnt_valid;

    // Advance the model to the next cycle.
    if (!rst) begin
      if (flush) begin
        m_owner = -1;
        m_beats = 0;
        m_last  = NUM_REQ - 1;
      end else if (m_owner < 0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (m_owner < 0 && bus.req_valid[(m_last + k) % NUM_REQ]) begin
            m_owner = (m_last + k) % NUM_REQ;
            m_beats = 0;
          end
        end
      end else if (!bus.req_valid[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (exp_wr) begin
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.full      = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    step(2);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_gnt_valid", bus.gnt_valid, 0);
    chk("rst_gnt_id", bus.gnt_id, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_D_in", bus.D_in, 0);
    rst = 1'b0;

    // Reset asserted during beat 2 of a req0 burst.
    bus.req_valid = 4'b0001;
    step(2);
    chk("t1_beat2_wr_en", bus.wr_en, 1);
    rst = 1'b1;
    #1;
    chk("t1_rst_wr_en", bus.wr_en, 0);
    chk("t1_rst_gnt_valid", bus.gnt_valid, 0);
    step(1);
    rst = 1'b0;
    bus.req_valid = 4'b0011;
    step(1);
    chk("t1_first_gnt_valid", bus.gnt_valid, 1);
    chk("t1_first_gnt_id", bus.gnt_id, 0);
    bus.req_valid = '0;
    step(4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(1);

    // All four requesters continuously valid.
    grant_q.delete();
    wr_q.delete();
    wr_cnt = 0;
    bus.req_valid = 4'hF;
    step(21);
    chk("t2_writes_20cyc", wr_cnt, 16);
    step(1);
    chk("t2_grant_count", (grant_q.size() >= 5) ? 1 : 0, 1);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t2_grant%0d", i), (i < grant_q.size()) ? grant_q[i] : 99, i % 4);
    chk("t2_data0", (wr_q.size() > 0) ? wr_q[0] : 8'hEE, 8'h11);
    chk("t2_data4", (wr_q.size() > 4) ? wr_q[4] : 8'hEE, 8'h22);
    chk("t2_data12", (wr_q.size() > 12) ? wr_q[12] : 8'hEE, 8'h44);
    bus.req_valid = '0;
    step(4);

    // req2 alone sends A5, 5A then drops valid.
    wr_q.delete();
    bus.req_data[2*DATA_W +: DATA_W] = 8'hA5;
    bus.req_valid = 4'b0100;
    step(2);
    bus.req_data[2*DATA_W +: DATA_W] = 8'h5A;
    step(1);
    bus.req_valid = '0;
    step(1);
    chk("t3_idle_gnt_valid", bus.gnt_valid, 0);
    chk("t3_nwrites", wr_q.size(), 2);
    chk("t3_byte0", (wr_q.size() > 0) ? wr_q[0] : 8'hEE, 8'hA5);
    chk("t3_byte1", (wr_q.size() > 1) ? wr_q[1] : 8'hEE, 8'h5A);
    bus.req_valid = 4'b1100;
    step(1);
    chk("t3_next_gnt_id", bus.gnt_id, 3);
    bus.req_valid = '0;
    step(3);

    // FIFO full for three cycles in the middle of a req1 burst.
    bus.req_valid = 4'b0010;
    step(3);
    bus.full = 1'b1;
    #1;
    chk("t4_stall_wr_en", bus.wr_en, 0);
    chk("t4_stall_ready", bus.req_ready, 0);
    chk("t4_stall_gnt_valid", bus.gnt_valid, 1);
    chk("t4_stall_gnt_id", bus.gnt_id, 1);
    step(3);
    bus.full = 1'b0;
    step(2);
    bus.req_valid = '0;
    step(2);
    chk("t4_burst_len", last_burst, 4);

    // flush during a req3 burst.
    bus.req_valid = 4'b1000;
    step(2);
    flush = 1'b1;
    #1;
    chk("t5_flush_wr_en", bus.wr_en, 0);
    chk("t5_flush_ready", bus.req_ready, 0);
    step(1);
    flush = 1'b0;
    chk("t5_idle_gnt_valid", bus.gnt_valid, 0);
    bus.req_valid = 4'b1001;
    step(1);
    chk("t5_gnt_valid", bus.gnt_valid, 1);
    chk("t5_gnt_id", bus.gnt_id, 0);
    bus.req_valid = '0;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
